// File: rtl/inv_sbox.sv
// AES inverse S-box (FIPS-197 Fig.14), purely combinational lookup.
// Ports:
//   a_i  input  [7:0]  byte to substitute
//   y_o  output [7:0]  InvSubBytes(a_i)
module inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  localparam logic [0:2047] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign y_o = TBL[{a_i, 3'b000} +: 8];

endmodule

// File: rtl/sbox.sv
// AES forward S-box (FIPS-197 Fig.7), purely combinational lookup.
// Ports:
//   a_i  input  [7:0]  byte to substitute
//   y_o  output [7:0]  SubBytes(a_i)
module sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  // Entry n occupies bits 8n..8n+7; the first literal holds entries 00..0f.
  localparam logic [0:2047] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y_o = TBL[{a_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher. Expands all 11 round keys forward into a
// local register file (one per cycle), then runs decryption rounds 10..0 at one
// round per cycle. Stored round keys may be reused for the next block.
// Ports:
//   CLK10MHZ   input          design clock, rising edge
//   reset      input          synchronous active-high reset
//   start      input          request, accepted only while ready=1
//   key_reuse  input          skip expansion when key_valid=1 (if KEY_REUSE_EN)
//   key_in     input  [0:127] cipher key, byte 0 = key_in[0:7]
//   ct_in      input  [0:127] ciphertext, byte 0 = ct_in[0:7]
//   ready      output         high in IDLE only
//   done       output         one-cycle pulse when pt_out updates
//   key_valid  output         round-key file holds a complete expansion
//   pt_out     output [0:127] plaintext, held until the next done
module aes_inv_cipher #(
  parameter bit KEY_REUSE_EN = 1'b1
) (
  input  logic         CLK10MHZ,
  input  logic         reset,
  input  logic         start,
  input  logic         key_reuse,
  input  logic [0:127] key_in,
  input  logic [0:127] ct_in,
  output logic         ready,
  output logic         done,
  output logic         key_valid,
  output logic [0:127] pt_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXPAND = 3'd1,
    S_INIT   = 3'd2,
    S_ROUND  = 3'd3,
    S_FINAL  = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [0:127] st_q, st_d;
  logic [0:127] pt_q, pt_d;
  logic         kv_q, kv_d;
  logic         done_q, done_d;

  logic [0:127] rk_q [0:10];
  logic         rk_we;
  logic [3:0]   rk_widx;
  logic [0:127] rk_wdata;

  // ---------------- key expansion: rk[r] from rk[r-1] ----------------
  logic [0:127] kprev;
  logic [7:0]   rcon;
  logic [7:0]   sw [4];
  logic [31:0]  ktemp, kw0, kw1, kw2, kw3;

  assign kprev = rk_q[rnd_q - 4'd1];

  always_comb begin
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // RotWord folded into the S-box input wiring: sw[j] = S(w3 byte (j+1)%4).
  for (genvar j = 0; j < 4; j++) begin : g_subword
    sbox u_sbox (
      .a_i(kprev[96 + 8*((j + 1) % 4) +: 8]),
      .y_o(sw[j])
    );
  end

  assign ktemp = {sw[0] ^ rcon, sw[1], sw[2], sw[3]};
  assign kw0   = kprev[0:31]  ^ ktemp;
  assign kw1   = kprev[32:63] ^ kw0;
  assign kw2   = kprev[64:95] ^ kw1;
  assign kw3   = kprev[96:127] ^ kw2;

  // ---------------- InvShiftRows + InvSubBytes ----------------
  // Row r of the state is rotated right by r: output byte (r,c) comes from (r,c-r).
  logic [0:127] isb;

  for (genvar i = 0; i < 16; i++) begin : g_invsub
    localparam int SRC = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
    inv_sbox u_inv_sbox (
      .a_i(st_q[8*SRC +: 8]),
      .y_o(isb[8*i +: 8])
    );
  end

  // ---------------- AddRoundKey + InvMixColumns ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    for (int unsigned k = 0; k < 4; k++) begin
      a[k]  = col[31 - 8*k -: 8];
      x2    = xt(a[k]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [0:127] ark, mixed;
  assign ark = isb ^ rk_q[rnd_q];

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mixed[32*c +: 32] = inv_mix_col(ark[32*c +: 32]);
  end

  // ---------------- control ----------------
  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    st_d     = st_q;
    pt_d     = pt_q;
    kv_d     = kv_q;
    done_d   = 1'b0;
    rk_we    = 1'b0;
    rk_widx  = rnd_q;
    rk_wdata = {kw0, kw1, kw2, kw3};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          st_d = ct_in;
          if (KEY_REUSE_EN && key_reuse && kv_q) begin
            state_d = S_INIT;
          end else begin
            rk_we    = 1'b1;
            rk_widx  = 4'd0;
            rk_wdata = key_in;
            kv_d     = 1'b0;
            rnd_d    = 4'd1;
            state_d  = S_EXPAND;
          end
        end
      end
      S_EXPAND: begin
        rk_we = 1'b1;
        if (rnd_q == 4'd10) begin
          kv_d    = 1'b1;
          state_d = S_INIT;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_INIT: begin
        st_d    = st_q ^ rk_q[10];
        rnd_d   = 4'd9;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        st_d  = mixed;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = S_FINAL;
      end
      S_FINAL: begin
        pt_d    = isb ^ rk_q[0];
        done_d  = 1'b1;
        rnd_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK10MHZ) begin
    if (reset) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
      pt_q    <= '0;
      kv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
      kv_q    <= kv_d;
      done_q  <= done_d;
    end
  end

  // Round-key contents are don't-care after reset, so the file carries no reset.
  always_ff @(posedge CLK10MHZ) begin
    if (rk_we) rk_q[rk_widx] <= rk_wdata;
  end

  assign ready     = (state_q == S_IDLE);
  assign done      = done_q;
  assign key_valid = kv_q;
  assign pt_out    = pt_q;

endmodule
